// File: rtl/alu_ctrl_sequencer.sv
// ---------------------------------------------------------------------------
// alu_ctrl_sequencer
// Hardwired T0..T6 control-step sequencer for one instruction fetch followed by
// a register-register ALU operation. It drives the Datapath strobes, decodes
// the IR the Datapath returns, and counts retired instructions.
//
// Ports:
//   clock       - system clock, rising edge
//   clear       - asynchronous active-low reset
//   run         - level; permits starting a new instruction
//   mem_ready   - memory data valid on Mdatain this cycle
//   IR          - Datapath IR (op=[31:27] Ra=[26:23] Rb=[22:19] Rc=[18:15])
//   PCout..LOin - Datapath strobes
//   Rout_sel    - one-hot register drive-to-bus select
//   Rin_sel     - one-hot register load select
//   opcode      - ALU operation, valid in T4..T6, zero elsewhere
//   done        - pulse in the final step of an instruction
//   fault       - sticky illegal-opcode / read-timeout flag
//   instr_count - retired-instruction count (wraps)
//
// Optional feature: define ALU_CTRL_READ_TIMEOUT_EN to abort a fetch that
// waits TIMEOUT_CYCLES cycles in T1/T1W without mem_ready (goes to FAULT).
// Without the macro T1W waits indefinitely.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module alu_ctrl_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             run,
    input  logic             mem_ready,
    input  logic [31:0]      IR,
    output logic             PCout,
    output logic             PCin,
    output logic             IncPC,
    output logic             MARin,
    output logic             Read,
    output logic             MDRin,
    output logic             MDRout,
    output logic             IRin,
    output logic             Yin,
    output logic             Zin,
    output logic             Zlowout,
    output logic             Zhighout,
    output logic             HIin,
    output logic             LOin,
    output logic [15:0]      Rout_sel,
    output logic [15:0]      Rin_sel,
    output logic [4:0]       opcode,
    output logic             done,
    output logic             fault,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        StIdle, StT0, StT1, StT1W, StT2, StT3, StT4, StT5, StT6, StFault
    } state_e;

    state_e r_state, w_state_next;

    logic [4:0] w_op;
    logic [3:0] w_ra, w_rb, w_rc;
    logic       w_legal, w_muldiv, w_unary, w_eoi, w_timeout;

    assign w_op     = IR[31:27];
    assign w_ra     = IR[26:23];
    assign w_rb     = IR[22:19];
    assign w_rc     = IR[18:15];
    assign w_legal  = (w_op <= 5'h10);
    assign w_muldiv = (w_op == 5'h0D) || (w_op == 5'h0E);
    assign w_unary  = (w_op == 5'h0F) || (w_op == 5'h10);
    // Instruction retires in T5 (single-result ops) or T6 (mul/div).
    assign w_eoi    = ((r_state == StT5) && !w_muldiv) || (r_state == StT6);

`ifdef ALU_CTRL_READ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_wait_cnt;

    // Timeout fires on the cycle whose increment would reach TIMEOUT_CYCLES.
    assign w_timeout = !mem_ready && (r_wait_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_wait_cnt <= '0;
        end else if (r_state == StT0) begin
            r_wait_cnt <= '0;
        end else if (((r_state == StT1) || (r_state == StT1W)) && !mem_ready) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_state     <= StIdle;
            instr_count <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_eoi) begin
                instr_count <= instr_count + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (run) w_state_next = StT0;
            StT0:    w_state_next = StT1;
            StT1, StT1W: begin
                if (mem_ready)      w_state_next = StT2;
                else if (w_timeout) w_state_next = StFault;
                else                w_state_next = StT1W;
            end
            StT2:    w_state_next = StT3;
            StT3:    w_state_next = w_legal ? StT4 : StFault;
            StT4:    w_state_next = StT5;
            StT5: begin
                if (w_muldiv) w_state_next = StT6;
                else          w_state_next = run ? StT0 : StIdle;
            end
            StT6:    w_state_next = run ? StT0 : StIdle;
            StFault: w_state_next = StFault;
            default: w_state_next = StIdle;
        endcase
    end

    // Moore outputs: state register plus IR only.
    always_comb begin
        PCout    = 1'b0;
        PCin     = 1'b0;
        IncPC    = 1'b0;
        MARin    = 1'b0;
        Read     = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        Zin      = 1'b0;
        Zlowout  = 1'b0;
        Zhighout = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        Rout_sel = '0;
        Rin_sel  = '0;
        opcode   = '0;
        done     = 1'b0;
        fault    = 1'b0;
        unique case (r_state)
            StT0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
            end
            StT1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            StT1W: begin
                Read  = 1'b1;
                MDRin = 1'b1;
            end
            StT2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            StT3: begin
                Rout_sel = 16'h0001 << w_rb;
                Yin      = 1'b1;
            end
            StT4: begin
                opcode   = w_op;
                Zin      = 1'b1;
                Rout_sel = 16'h0001 << (w_unary ? w_rb : w_rc);
            end
            StT5: begin
                opcode  = w_op;
                Zlowout = 1'b1;
                if (w_muldiv) begin
                    LOin = 1'b1;
                end else begin
                    Rin_sel = 16'h0001 << w_ra;
                    done    = 1'b1;
                end
            end
            StT6: begin
                opcode   = w_op;
                Zhighout = 1'b1;
                HIin     = 1'b1;
                done     = 1'b1;
            end
            StFault: fault = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_ctrl_sequencer.sv
`timescale 1ns/1ps
module tb_alu_ctrl_sequencer;

    logic        clock = 1'b0;
    logic        clear, run, mem_ready;
    logic [31:0] IR;
    logic PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin, Yin, Zin;
    logic Zlowout, Zhighout, HIin, LOin, done, fault;
    logic [15:0] Rout_sel, Rin_sel;
    logic [4:0]  opcode;
    logic [15:0] instr_count;

    int n_checks = 0;
    int n_pass   = 0;

    // Strobe bundle order: PCout PCin IncPC MARin Read MDRin MDRout IRin
    //                      Yin Zin Zlowout Zhighout HIin LOin
    localparam logic [13:0] S_0   = 14'h0000;
    localparam logic [13:0] S_T0  = 14'h2C10;
    localparam logic [13:0] S_T1  = 14'h1308;
    localparam logic [13:0] S_T1W = 14'h0300;
    localparam logic [13:0] S_T2  = 14'h00C0;
    localparam logic [13:0] S_T3  = 14'h0020;
    localparam logic [13:0] S_T4  = 14'h0010;
    localparam logic [13:0] S_T5  = 14'h0008;
    localparam logic [13:0] S_T5M = 14'h0009;
    localparam logic [13:0] S_T6  = 14'h0006;

    alu_ctrl_sequencer #(.TIMEOUT_CYCLES(4), .CNT_W(16)) dut (
        .clock(clock), .clear(clear), .run(run), .mem_ready(mem_ready), .IR(IR),
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .Read(Read),
        .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin),
        .Zlowout(Zlowout), .Zhighout(Zhighout), .HIin(HIin), .LOin(LOin),
        .Rout_sel(Rout_sel), .Rin_sel(Rin_sel), .opcode(opcode), .done(done),
        .fault(fault), .instr_count(instr_count)
    );

    always #5 clock = ~clock;

    function automatic logic [52:0] obs();
        return {PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin, Yin, Zin,
                Zlowout, Zhighout, HIin, LOin, Rout_sel, Rin_sel, opcode, done, fault};
    endfunction

    function automatic logic [52:0] ev(input logic [13:0] s, input logic [15:0] ro,
                                       input logic [15:0] ri, input logic [4:0] op,
                                       input logic d, input logic f);
        return {s, ro, ri, op, d, f};
    endfunction

    task automatic test_reset;
        clear = 1'b0; run = 1'b0; mem_ready = 1'b0; IR = '0;
        repeat (2) @(negedge clock);
        n_checks++;
        if (obs() !== 53'h0 || instr_count !== 16'h0)
            $display("FAIL reset: got %h cnt %h expected 0 cnt 0", obs(), instr_count);
        else n_pass++;
        clear = 1'b1;
        @(negedge clock);
        n_checks++;
        if (obs() !== 53'h0) $display("FAIL reset_idle: got %h expected 0", obs());
        else n_pass++;
    endtask

    task automatic test_and;
        logic [52:0] e [0:5];
        e[0] = ev(S_T0, 16'h0, 16'h0, 5'h0, 1'b0, 1'b0);
        e[1] = ev(S_T1, 16'h0, 16'h0, 5'h0, 1'b0, 1'b0);
        e[2] = ev(S_T2, 16'h0, 16'h0, 5'h0, 1'b0, 1'b0);
        e[3] = ev(S_T3, 16'h0004, 16'h0, 5'h0, 1'b0, 1'b0);
        e[4] = ev(S_T4, 16'h0008, 16'h0, 5'h0, 1'b0, 1'b0);
        e[5] = ev(S_T5, 16'h0, 16'h0002, 5'h0, 1'b1, 1'b0);
        IR = 32'h00918000; mem_ready = 1'b1; run = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            run = 1'b0;
            n_checks++;
            if (obs() !== e[i]) $display("FAIL and step %0d: got %h expected %h", i, obs(), e[i]);
            else n_pass++;
        end
        @(negedge clock);
        n_checks++;
        if (obs() !== 53'h0 || instr_count !== 16'd1)
            $display("FAIL and_end: got %h cnt %0d expected 0 cnt 1", obs(), instr_count);
        else n_pass++;
    endtask

    task automatic test_mul;
        logic [52:0] e [0:6];
        e[0] = ev(S_T0, 16'h0, 16'h0, 5'h0, 1'b0, 1'b0);
        e[1] = ev(S_T1, 16'h0, 16'h0, 5'h0, 1'b0, 1'b0);
        e[2] = ev(S_T2, 16'h0, 16'h0, 5'h0, 1'b0, 1'b0);
        e[3] = ev(S_T3, 16'h0010, 16'h0, 5'h0, 1'b0, 1'b0);
        e[4] = ev(S_T4, 16'h0020, 16'h0, 5'h0D, 1'b0, 1'b0);
        e[5] = ev(S_T5M, 16'h0, 16'h0, 5'h0D, 1'b0, 1'b0);
        e[6] = ev(S_T6, 16'h0, 16'h0, 5'h0D, 1'b1, 1'b0);
        IR = 32'h68228000; mem_ready = 1'b1; run = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clock);
            run = 1'b0;
            n_checks++;
            if (obs() !== e[i]) $display("FAIL mul step %0d: got %h expected %h", i, obs(), e[i]);
            else n_pass++;
        end
        @(negedge clock);
        n_checks++;
        if (obs() !== 53'h0 || instr_count !== 16'd2)
            $display("FAIL mul_end: got %h cnt %0d expected 0 cnt 2", obs(), instr_count);
        else n_pass++;
    endtask

    // neg R3,R7 with three wait cycles on the fetch read
    task automatic test_mem_wait;
        logic [52:0] e [0:8];
        e[0] = ev(S_T0, 16'h0, 16'h0, 5'h0, 1'b0, 1'b0);
        e[1] = ev(S_T1, 16'h0, 16'h0, 5'h0, 1'b0, 1'b0);
        e[2] = ev(S_T1W, 16'h0, 16'h0, 5'h0, 1'b0, 1'b0);
        e[3] = ev(S_T1W, 16'h0, 16'h0, 5'h0, 1'b0, 1'b0);
        e[4] = ev(S_T1W, 16'h0, 16'h0, 5'h0, 1'b0, 1'b0);
        e[5] = ev(S_T2, 16'h0, 16'h0, 5'h0, 1'b0, 1'b0);
        e[6] = ev(S_T3, 16'h0080, 16'h0, 5'h0, 1'b0, 1'b0);
        e[7] = ev(S_T4, 16'h0080, 16'h0, 5'h0F, 1'b0, 1'b0);
        e[8] = ev(S_T5, 16'h0, 16'h0008, 5'h0F, 1'b1, 1'b0);
        IR = 32'h79B80000; mem_ready = 1'b0; run = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clock);
            run = 1'b0;
            n_checks++;
            if (obs() !== e[i]) $display("FAIL wait step %0d: got %h expected %h", i, obs(), e[i]);
            else n_pass++;
            if (i == 4) mem_ready = 1'b1;
        end
        @(negedge clock);
        n_checks++;
        if (instr_count !== 16'd3) $display("FAIL wait_cnt: got %0d expected 3", instr_count);
        else n_pass++;
    endtask

    // not R5,R9: highest legal opcode, unary drive of Rb in T4
    task automatic test_not;
        logic [52:0] e [0:2];
        e[0] = ev(S_T3, 16'h0200, 16'h0, 5'h0, 1'b0, 1'b0);
        e[1] = ev(S_T4, 16'h0200, 16'h0, 5'h10, 1'b0, 1'b0);
        e[2] = ev(S_T5, 16'h0, 16'h0020, 5'h10, 1'b1, 1'b0);
        IR = 32'h82C80000; mem_ready = 1'b1; run = 1'b1;
        repeat (3) begin
            @(negedge clock);
            run = 1'b0;
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            n_checks++;
            if (obs() !== e[i]) $display("FAIL not step %0d: got %h expected %h", i, obs(), e[i]);
            else n_pass++;
        end
        @(negedge clock);
        n_checks++;
        if (obs() !== 53'h0 || instr_count !== 16'd4)
            $display("FAIL not_end: got %h cnt %0d expected 0 cnt 4", obs(), instr_count);
        else n_pass++;
    endtask

    task automatic test_illegal(input logic [31:0] ir, input int hold);
        logic [52:0] e_t3, e_f;
        e_t3 = ev(S_T3, 16'h0001, 16'h0, 5'h0, 1'b0, 1'b0);
        e_f  = ev(S_0, 16'h0, 16'h0, 5'h0, 1'b0, 1'b1);
        IR = ir; mem_ready = 1'b1; run = 1'b1;
        repeat (4) @(negedge clock);
        n_checks++;
        if (obs() !== e_t3) $display("FAIL illegal_t3: got %h expected %h", obs(), e_t3);
        else n_pass++;
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            n_checks++;
            if (obs() !== e_f) $display("FAIL illegal_hold %0d: got %h expected %h", i, obs(), e_f);
            else n_pass++;
        end
        #2 clear = 1'b0;
        #1;
        n_checks++;
        if (obs() !== 53'h0 || instr_count !== 16'h0)
            $display("FAIL illegal_clear: got %h cnt %0d expected 0 cnt 0", obs(), instr_count);
        else n_pass++;
        run = 1'b0;
        clear = 1'b1;
        @(negedge clock);
        n_checks++;
        if (obs() !== 53'h0) $display("FAIL illegal_idle: got %h expected 0", obs());
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic [52:0] e [0:10];
        e[0] = ev(S_T0, 16'h0, 16'h0, 5'h0, 1'b0, 1'b0);
        e[1] = ev(S_T1, 16'h0, 16'h0, 5'h0, 1'b0, 1'b0);
        e[2] = ev(S_T2, 16'h0, 16'h0, 5'h0, 1'b0, 1'b0);
        e[3] = ev(S_T3, 16'h0004, 16'h0, 5'h0, 1'b0, 1'b0);
        e[4] = ev(S_T4, 16'h0008, 16'h0, 5'h0, 1'b0, 1'b0);
        e[5] = ev(S_T5, 16'h0, 16'h0002, 5'h0, 1'b1, 1'b0);
        for (int i = 6; i < 11; i++) e[i] = e[i-6];
        IR = 32'h00918000; mem_ready = 1'b1; run = 1'b1;
        for (int i = 0; i < 11; i++) begin
            @(negedge clock);
            n_checks++;
            if (obs() !== e[i]) $display("FAIL b2b step %0d: got %h expected %h", i, obs(), e[i]);
            else n_pass++;
        end
        n_checks++;
        if (instr_count !== 16'd1) $display("FAIL b2b_cnt: got %0d expected 1", instr_count);
        else n_pass++;
        #1 clear = 1'b0;
        run = 1'b0;
        #1;
        n_checks++;
        if (obs() !== 53'h0 || instr_count !== 16'h0)
            $display("FAIL b2b_async_clear: got %h cnt %0d expected 0 cnt 0", obs(), instr_count);
        else n_pass++;
        #1 clear = 1'b1;
        @(negedge clock);
        n_checks++;
        if (obs() !== 53'h0 || instr_count !== 16'h0)
            $display("FAIL b2b_idle: got %h cnt %0d expected 0 cnt 0", obs(), instr_count);
        else n_pass++;
    endtask

`ifdef ALU_CTRL_READ_TIMEOUT_EN
    task automatic test_timeout;
        logic [52:0] e_f, e_t2;
        e_f  = ev(S_0, 16'h0, 16'h0, 5'h0, 1'b0, 1'b1);
        e_t2 = ev(S_T2, 16'h0, 16'h0, 5'h0, 1'b0, 1'b0);
        IR = 32'h00918000; mem_ready = 1'b0; run = 1'b1;
        repeat (6) begin
            @(negedge clock);
            run = 1'b0;
        end
        n_checks++;
        if (obs() !== e_f) $display("FAIL timeout_fault: got %h expected %h", obs(), e_f);
        else n_pass++;
        clear = 1'b0;
        #1 clear = 1'b1;
        run = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            run = 1'b0;
            if (i == 4) mem_ready = 1'b1;
        end
        n_checks++;
        if (obs() !== e_t2) $display("FAIL timeout_late_ready: got %h expected %h", obs(), e_t2);
        else n_pass++;
        repeat (4) @(negedge clock);
    endtask
`endif

    initial begin
        test_reset();
        test_and();
        test_mul();
        test_mem_wait();
        test_not();
        test_illegal(32'hF8000000, 22);
        test_illegal(32'h88000000, 2);
        test_back_to_back();
`ifdef ALU_CTRL_READ_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
